// File: rtl/gpio_arb_pkg.sv
`default_nettype none
// gpio_arb_pkg: shared types, bus widths and width helpers for the GPIO register-bus arbiter.
// Revision: 1.0
package gpio_arb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  // Watchdog counter width; never narrower than one bit.
  function automatic int cnt_width(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    return (w < 1) ? 1 : w;
  endfunction

  // Requester index width; never narrower than one bit.
  function automatic int idx_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gpio_rr_picker.sv
`default_nettype none
// gpio_rr_picker: combinational round-robin pick of the first set request at or after rr_ptr.
// Revision: 1.0
module gpio_rr_picker
  import gpio_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic               valid,
  output logic [IDX_W-1:0]   index
);

  int cand;

  always_comb begin
    valid = 1'b0;
    index = '0;
    cand  = 0;
    // Walk from the farthest offset down so the nearest candidate is written last.
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      cand = int'(rr_ptr) + off;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      if (req[cand]) begin
        valid = 1'b1;
        index = IDX_W'(cand);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/gpio_bus_arbiter.sv
`default_nettype none
// gpio_bus_arbiter: round-robin sharing of the gpio_regs register bus with a no-ack watchdog.
// Revision: 1.0
module gpio_bus_arbiter
  import gpio_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 16
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_REQ-1:0]          m_req,
  input  logic [NUM_REQ-1:0]          m_we,
  input  logic [NUM_REQ*ADDR_W-1:0]   m_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   m_wdata,
  input  logic [NUM_REQ*BE_W-1:0]     m_be,
  output logic [NUM_REQ-1:0]          m_ack,
  output logic [NUM_REQ-1:0]          m_err,
  output logic [DATA_W-1:0]           m_rdata,
  output logic [ADDR_W-1:0]           s_addr,
  output logic [DATA_W-1:0]           s_wdata,
  output logic                        s_we,
  output logic                        s_re,
  output logic [BE_W-1:0]             s_be,
  input  logic                        s_ack,
  input  logic [DATA_W-1:0]           s_rdata,
  output logic [idx_width(NUM_REQ)-1:0] grant_id,
  output logic                        busy
);

  localparam int IDX_W = idx_width(NUM_REQ);
  localparam int CNT_W = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);
  localparam bit WDOG_EN = (TIMEOUT != 0);

  arb_state_e          state_q, state_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]    grant_q, grant_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   s_addr_q, s_addr_d;
  logic [DATA_W-1:0]   s_wdata_q, s_wdata_d;
  logic [BE_W-1:0]     s_be_q, s_be_d;
  logic                s_we_q, s_we_d;
  logic                s_re_q, s_re_d;
  logic [NUM_REQ-1:0]  m_ack_q, m_ack_d;
  logic [NUM_REQ-1:0]  m_err_q, m_err_d;
  logic [DATA_W-1:0]   m_rdata_q, m_rdata_d;
  logic                busy_q, busy_d;

  logic                pick_valid;
  logic [IDX_W-1:0]    pick_idx;

  gpio_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req    (m_req),
    .rr_ptr (rr_ptr_q),
    .valid  (pick_valid),
    .index  (pick_idx)
  );

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    grant_d   = grant_q;
    cnt_d     = cnt_q;
    s_addr_d  = s_addr_q;
    s_wdata_d = s_wdata_q;
    s_be_d    = s_be_q;
    s_we_d    = s_we_q;
    s_re_d    = s_re_q;
    m_rdata_d = m_rdata_q;
    m_ack_d   = '0;
    m_err_d   = '0;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d   = pick_idx;
          s_addr_d  = m_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
          s_wdata_d = m_wdata[int'(pick_idx)*DATA_W +: DATA_W];
          s_be_d    = m_be[int'(pick_idx)*BE_W +: BE_W];
          s_we_d    = m_we[pick_idx];
          s_re_d    = ~m_we[pick_idx];
          cnt_d     = '0;
          state_d   = ACCESS;
        end
      end
      ACCESS: begin
        // An ack in the expiry cycle still completes the access normally.
        if (s_ack) begin
          m_rdata_d         = s_rdata;
          s_we_d            = 1'b0;
          s_re_d            = 1'b0;
          m_ack_d[grant_q]  = 1'b1;
          state_d           = RESP;
        end else if (WDOG_EN && (cnt_q == CNT_LAST)) begin
          s_we_d            = 1'b0;
          s_re_d            = 1'b0;
          m_err_d[grant_q]  = 1'b1;
          state_d           = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        rr_ptr_d = (grant_q == IDX_LAST) ? '0 : grant_q + 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      cnt_q     <= '0;
      s_addr_q  <= '0;
      s_wdata_q <= '0;
      s_be_q    <= '0;
      s_we_q    <= 1'b0;
      s_re_q    <= 1'b0;
      m_ack_q   <= '0;
      m_err_q   <= '0;
      m_rdata_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      cnt_q     <= cnt_d;
      s_addr_q  <= s_addr_d;
      s_wdata_q <= s_wdata_d;
      s_be_q    <= s_be_d;
      s_we_q    <= s_we_d;
      s_re_q    <= s_re_d;
      m_ack_q   <= m_ack_d;
      m_err_q   <= m_err_d;
      m_rdata_q <= m_rdata_d;
      busy_q    <= busy_d;
    end
  end

  assign m_ack    = m_ack_q;
  assign m_err    = m_err_q;
  assign m_rdata  = m_rdata_q;
  assign s_addr   = s_addr_q;
  assign s_wdata  = s_wdata_q;
  assign s_we     = s_we_q;
  assign s_re     = s_re_q;
  assign s_be     = s_be_q;
  assign grant_id = grant_q;
  assign busy     = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_gpio_bus_arbiter.sv
`default_nettype none
// tb_gpio_bus_arbiter: directed tests for gpio_bus_arbiter (TIMEOUT=16 and a TIMEOUT=1 instance).
// Revision: 1.0
module tb_gpio_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  m_req = '0;
  logic [1:0]  m_we = '0;
  logic [63:0] m_addr = '0;
  logic [63:0] m_wdata = '0;
  logic [7:0]  m_be = '0;
  logic        s_ack = 1'b0;
  logic        s_ack2 = 1'b0;
  logic [31:0] s_rdata = '0;

  logic [1:0]  m_ack, m_err, m_ack2, m_err2;
  logic [31:0] m_rdata, m_rdata2, s_addr, s_addr2, s_wdata, s_wdata2;
  logic        s_we, s_re, s_we2, s_re2, busy, busy2;
  logic [3:0]  s_be, s_be2;
  logic [0:0]  grant_id, grant_id2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  gpio_bus_arbiter #(.NUM_REQ(2), .TIMEOUT(16)) dut (
    .clk(clk), .reset_n(reset_n), .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_be(m_be), .m_ack(m_ack), .m_err(m_err), .m_rdata(m_rdata),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_we(s_we), .s_re(s_re), .s_be(s_be),
    .s_ack(s_ack), .s_rdata(s_rdata), .grant_id(grant_id), .busy(busy)
  );

  gpio_bus_arbiter #(.NUM_REQ(2), .TIMEOUT(1)) dut_t1 (
    .clk(clk), .reset_n(reset_n), .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_be(m_be), .m_ack(m_ack2), .m_err(m_err2), .m_rdata(m_rdata2),
    .s_addr(s_addr2), .s_wdata(s_wdata2), .s_we(s_we2), .s_re(s_re2), .s_be(s_be2),
    .s_ack(s_ack2), .s_rdata(s_rdata), .grant_id(grant_id2), .busy(busy2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    m_req   = '0;
    s_ack   = 1'b0;
    s_ack2  = 1'b0;
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({s_we, s_re, busy, grant_id} !== 4'b0) begin
      failures++; $display("FAIL reset_ctrl got=%b want=0000", {s_we, s_re, busy, grant_id});
    end
    checks++;
    if ({m_ack, m_err, m_rdata, s_addr, s_wdata, s_be} !== '0) begin
      failures++; $display("FAIL reset_data got=%h want=0", {m_ack, m_err, m_rdata, s_addr, s_wdata, s_be});
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single_read();
    int hi;
    m_addr[31:0] = 32'h8;
    m_we = 2'b00;
    m_req = 2'b01;
    tick();
    hi = s_re ? 1 : 0;
    checks++;
    if (s_addr !== 32'h8 || grant_id !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL read_issue addr=%h grant=%0d busy=%b want addr=8 grant=0 busy=1", s_addr, grant_id, busy);
    end
    tick();
    if (s_re) hi++;
    tick();
    if (s_re) hi++;
    s_ack = 1'b1;
    s_rdata = 32'hA5A5_0001;
    tick();
    s_ack = 1'b0;
    m_req = 2'b00;
    checks++;
    if (hi !== 3 || s_re !== 1'b0) begin
      failures++; $display("FAIL read_re_len cycles=%0d s_re=%b want 3 and 0", hi, s_re);
    end
    checks++;
    if (m_ack !== 2'b01 || m_err !== 2'b00) begin
      failures++; $display("FAIL read_ack m_ack=%b m_err=%b want 01 00", m_ack, m_err);
    end
    checks++;
    if (m_rdata !== 32'hA5A5_0001) begin
      failures++; $display("FAIL read_data got=%h want=a5a50001", m_rdata);
    end
    tick();
    checks++;
    if (m_ack !== 2'b00 || busy !== 1'b0) begin
      failures++; $display("FAIL read_idle m_ack=%b busy=%b want 00 0", m_ack, busy);
    end
  endtask

  task automatic test_round_robin();
    logic [0:0] exp;
    do_reset();
    m_addr = {32'h20, 32'h10};
    m_we = 2'b00;
    m_req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      exp = 1'(k % 2);
      for (int w = 0; w < 20 && !s_re; w++) tick();
      checks++;
      if (s_re !== 1'b1 || grant_id !== exp || s_addr !== (exp ? 32'h20 : 32'h10)) begin
        failures++; $display("FAIL rr_grant access=%0d s_re=%b grant=%0d addr=%h want grant=%0d", k, s_re, grant_id, s_addr, exp);
      end
      s_ack = 1'b1;
      s_rdata = 32'(k);
      tick();
      s_ack = 1'b0;
      checks++;
      if (m_ack !== (2'b01 << exp) || grant_id !== exp) begin
        failures++; $display("FAIL rr_ack access=%0d m_ack=%b grant=%0d want owner %0d", k, m_ack, grant_id, exp);
      end
    end
    m_req = 2'b00;
    tick();
  endtask

  task automatic test_write();
    m_addr[63:32]  = 32'h4;
    m_wdata[63:32] = 32'h0000_00FF;
    m_be[7:4]      = 4'b0001;
    m_we  = 2'b10;
    m_req = 2'b10;
    tick();
    checks++;
    if (s_we !== 1'b1 || s_re !== 1'b0 || grant_id !== 1'b1) begin
      failures++; $display("FAIL wr_ctrl we=%b re=%b grant=%0d want 1 0 1", s_we, s_re, grant_id);
    end
    checks++;
    if (s_addr !== 32'h4 || s_wdata !== 32'hFF || s_be !== 4'b0001) begin
      failures++; $display("FAIL wr_data addr=%h wdata=%h be=%b want 4 ff 0001", s_addr, s_wdata, s_be);
    end
    // Return the current read value so m_rdata is unchanged either way.
    s_rdata = 32'h3;
    s_ack = 1'b1;
    tick();
    s_ack = 1'b0;
    m_req = 2'b00;
    checks++;
    if (m_ack !== 2'b10 || m_rdata !== 32'h3) begin
      failures++; $display("FAIL wr_ack m_ack=%b m_rdata=%h want 10 00000003", m_ack, m_rdata);
    end
    tick();
  endtask

  task automatic test_timeout();
    int hi;
    bit saw_ack;
    hi = 0;
    saw_ack = 1'b0;
    m_addr[31:0] = 32'hC;
    m_we  = 2'b00;
    m_req = 2'b01;
    tick();
    for (int w = 0; w < 40 && s_re; w++) begin
      hi++;
      if (m_ack != 2'b00) saw_ack = 1'b1;
      tick();
    end
    checks++;
    if (hi !== 16) begin
      failures++; $display("FAIL to_len access_cycles=%0d want=16", hi);
    end
    checks++;
    if (m_err !== 2'b01 || m_ack !== 2'b00 || saw_ack) begin
      failures++; $display("FAIL to_err m_err=%b m_ack=%b early_ack=%b want 01 00 0", m_err, m_ack, saw_ack);
    end
    tick();
    checks++;
    if (m_err !== 2'b00) begin
      failures++; $display("FAIL to_once m_err=%b want=00", m_err);
    end
    for (int w = 0; w < 20 && !s_re; w++) tick();
    s_ack = 1'b1;
    s_rdata = 32'h1234;
    tick();
    s_ack = 1'b0;
    m_req = 2'b00;
    checks++;
    if (m_ack !== 2'b01 || m_err !== 2'b00 || m_rdata !== 32'h1234) begin
      failures++; $display("FAIL to_next m_ack=%b m_err=%b rdata=%h want 01 00 00001234", m_ack, m_err, m_rdata);
    end
    tick();
  endtask

  task automatic test_reset_mid_access();
    m_addr[63:32] = 32'h30;
    m_we  = 2'b10;
    m_req = 2'b10;
    tick();
    checks++;
    if (s_we !== 1'b1 || grant_id !== 1'b1) begin
      failures++; $display("FAIL rst_pre we=%b grant=%0d want 1 1", s_we, grant_id);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({s_we, s_re, busy, grant_id, m_ack, m_err} !== 8'b0 || s_addr !== 32'h0 || s_wdata !== 32'h0) begin
      failures++; $display("FAIL rst_async we=%b re=%b busy=%b grant=%0d addr=%h want all 0", s_we, s_re, busy, grant_id, s_addr);
    end
    m_addr[31:0] = 32'h40;
    m_we  = 2'b00;
    m_req = 2'b11;
    tick();
    tick();
    checks++;
    if (m_ack !== 2'b00 || m_err !== 2'b00) begin
      failures++; $display("FAIL rst_nopulse m_ack=%b m_err=%b want 00 00", m_ack, m_err);
    end
    reset_n = 1'b1;
    tick();
    checks++;
    if (s_re !== 1'b1 || grant_id !== 1'b0 || s_addr !== 32'h40) begin
      failures++; $display("FAIL rst_regrant re=%b grant=%0d addr=%h want 1 0 00000040", s_re, grant_id, s_addr);
    end
    s_ack = 1'b1;
    tick();
    s_ack = 1'b0;
    m_req = 2'b00;
    tick();
  endtask

  task automatic test_timeout_one();
    do_reset();
    m_we  = 2'b00;
    m_req = 2'b01;
    tick();
    checks++;
    if (s_re2 !== 1'b1) begin
      failures++; $display("FAIL t1_issue s_re=%b want=1", s_re2);
    end
    s_ack2 = 1'b1;
    s_rdata = 32'h77;
    tick();
    s_ack2 = 1'b0;
    m_req = 2'b00;
    checks++;
    if (m_ack2 !== 2'b01 || m_err2 !== 2'b00) begin
      failures++; $display("FAIL t1_ack_wins m_ack=%b m_err=%b want 01 00", m_ack2, m_err2);
    end
    tick();
    m_req = 2'b01;
    tick();
    tick();
    m_req = 2'b00;
    checks++;
    if (s_re2 !== 1'b0 || m_err2 !== 2'b01 || m_ack2 !== 2'b00) begin
      failures++; $display("FAIL t1_expire s_re=%b m_err=%b m_ack=%b want 0 01 00", s_re2, m_err2, m_ack2);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_write();
    test_timeout();
    test_reset_mid_access();
    test_timeout_one();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL tb_watchdog simulation did not complete in time");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
